execute_stage_param: RTL and testbench
======================================

# execute_stage_param

Parametrised execute stage for the microprocessor datapath: owns the general-purpose register file, executes one decoded instruction per accepted request, writes the result back and updates the condition flags. It generalises the 8-bit single-cycle execute stage to configurable data width and register count. It adds a valid/ready handshake, an immediate addressing mode, a multi-cycle shift-add multiplier, rotate, and a sticky halt state. It sits between decode and the write-back/branch logic.

## Interface
- DATA_W, 8: operand/register width; must be ≥ 8.
- REG_ADDR_W, 3: register index width; register file has 2^REG_ADDR_W entries.
- SHAMT_W, 3: shift-amount width.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  one clock; reset is synchronous and active-high.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept; equals (state==IDLE && !halted).
- opcode  in  5  operation select.
- am  in  1  0: operand B = reg[rs2]; 1: operand B = imm.
- rd, rs1, rs2  in  REG_ADDR_W  destination / source indices.
- imm  in  DATA_W  immediate operand.
- s_r_amount  in  SHAMT_W  shift/rotate count.
- result  out  2*DATA_W  last completed result, zero-extended except MUL.
- out_valid  out  1  one-cycle pulse per completed instruction.
- zero_flag, carry_flag, ac_flag, parity_flag  out  1 each  condition flags.
- illegal_op  out  1  one-cycle pulse on an unrecognised opcode.
- halted  out  1  high after HLT until reset.

## Operation
- Accept occurs on an edge with in_valid && in_ready. Operand A = reg[rs1]. Operand B = am ? imm : reg[rs2].
- Opcodes:
  - 00000 NOP
  - 00001 ADD
  - 00010 SUB (A−B)
  - 00011 AND
  - 00100 OR
  - 00101 XOR
  - 00110 NOT A
  - 00111 MOV (B)
  - 01000 MUL
  - 01001 SHL A by s_r_amount
  - 01010 SHR (logical)
  - 01011 ROL
  - 01100 INC reg[rd]
  - 01101 CMP (SUB with flags only, no write-back)
  - 11111 HLT
- Any other opcode: no write-back, flags held, illegal_op and out_valid pulse, result unchanged.
- Write-back: reg[rd] ← low DATA_W bits of the result. Exceptions: NOP, CMP, HLT and illegal opcodes do not write back.
- Flags are updated by every op except NOP, HLT and illegal opcodes:
  - zero: the written DATA_W value is 0. For MUL, zero means the full 2·DATA_W product is 0.
  - carry:
    - ADD: carry out of bit DATA_W−1.
    - SUB/CMP: borrow (A<B unsigned).
    - SHL: last bit shifted out of the MSB; SHR: last bit shifted out of the LSB; both 0 when the amount is 0.
    - MUL: high half ≠ 0.
    - INC: carry out.
    - All others: 0.
  - ac: carry (ADD/INC) or borrow (SUB/CMP) out of bit 3; 0 for other ops.
  - parity: 1 when the low DATA_W bits of the result contain an even number of ones.
- MUL: unsigned shift-add over DATA_W iterations. result = full 2·DATA_W product; reg[rd] ← low half.
- HLT: sets halted; in_ready stays 0 and in_valid is ignored until reset. out_valid pulses once.
- FSM:
  - IDLE → MUL on accept of opcode 01000.
  - MUL → IDLE after the DATA_W-th iteration.
  - All other opcodes stay in IDLE.

## Timing
- Reset values (reset has priority over all other activity):
  - All registers, result and flags: 0.
  - out_valid and illegal_op: 0.
  - halted: 0; state: IDLE.
  - in_ready: 1 on the first cycle after reset deasserts.
- Single-cycle ops:
  - Compute, write-back, flags, result and out_valid are all registered on the accept edge, so they are visible the next cycle.
  - A back-to-back dependent instruction reads the updated register with no stall.
- MUL:
  - Operands are captured on accept edge E0. Iterations run on E1..E_DATA_W.
  - Write-back, flags and out_valid occur on E_DATA_W. in_ready is 0 from after E0 until after E_DATA_W.
  - Later changes to source registers cannot affect an in-flight MUL.
- rd == rs1 or rd == rs2 is legal; sources are read before the write.
- Reset during MUL aborts it: no write-back and no out_valid.
- in_valid while in_ready = 0: the instruction is not consumed; decode must hold it.

## Test plan
- Reset, then MOV am=1 rd=1 imm=0x0F, then ADD am=1 rd=2 rs1=1 imm=0x01.
  - Required: result 0x0010, reg2=0x10, ac=1, carry=0, zero=0, parity=0.
  - Required: out_valid pulses on each accept edge.
- SUB rd=3 rs1=1 rs2=1 → result 0x0000, zero=1, carry=0, parity=1. Then CMP of 0x00 vs reg1 → carry=1, reg3 unchanged.
- MOV reg5=0xFF, then MUL rd=4 rs1=5 rs2=5.
  - Required: in_ready low for 8 cycles; out_valid 8 cycles after accept.
  - Required: result 0xFE01, reg4=0x01, carry=1, zero=0.
- MOV reg6=0x81, then SHL by 1 → 0x02 carry=1; ROL by 1 → 0x03 carry=0; SHR 0x81 by 1 → 0x40 carry=1.
- Opcode 10110 → illegal_op pulse, flags and registers unchanged. Then HLT → halted=1, in_ready=0 for 20 cycles with in_valid=1; reset → in_ready=1, halted=0.
- Start MUL 0xFF×0xFF, assert reset at iteration 4 → out_valid never pulses, reg[rd]=0, result=0, state IDLE.

Source files
------------

// File: rtl/execute_stage_param.sv
// execute_stage_param: register file + ALU execute stage with valid/ready, immediate mode, shift-add MUL, halt; ports clk/reset, in_valid/in_ready, opcode/am/rd/rs1/rs2/imm/s_r_amount in, result/out_valid/flags/illegal_op/halted out
module execute_stage_param #(
  parameter int DATA_W = 8,
  parameter int REG_ADDR_W = 3,
  parameter int SHAMT_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            opcode,
  input  logic                  am,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0]     imm,
  input  logic [SHAMT_W-1:0]    s_r_amount,
  output logic [2*DATA_W-1:0]   result,
  output logic                  out_valid,
  output logic                  zero_flag,
  output logic                  carry_flag,
  output logic                  ac_flag,
  output logic                  parity_flag,
  output logic                  illegal_op,
  output logic                  halted
);
  localparam int NREG = 1 << REG_ADDR_W;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [4:0] OP_NOP = 5'b00000, OP_ADD = 5'b00001, OP_SUB = 5'b00010,
    OP_AND = 5'b00011, OP_OR = 5'b00100, OP_XOR = 5'b00101, OP_NOT = 5'b00110,
    OP_MOV = 5'b00111, OP_MUL = 5'b01000, OP_SHL = 5'b01001, OP_SHR = 5'b01010,
    OP_ROL = 5'b01011, OP_INC = 5'b01100, OP_CMP = 5'b01101, OP_HLT = 5'b11111;
  typedef enum logic {IDLE, MULS} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [2*DATA_W-1:0] result_q, mcand_q, acc_q, acc_d;
  logic [DATA_W-1:0] mplier_q, op_a, op_b, rd_val, alu_val;
  logic [REG_ADDR_W-1:0] mul_rd_q;
  logic [CW-1:0] cnt_q;
  logic [DATA_W:0] sum, dif, shl, shr;
  logic zero_q, carry_q, ac_q, parity_q, out_valid_q, illegal_q, halted_q;
  logic accept, last, alu_c, alu_ac, legal, wb, upd;
  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
  always_comb state_d = state_q == IDLE ? ((accept && opcode == OP_MUL) ? MULS : IDLE)
                                        : (last ? IDLE : MULS);
  always_comb in_ready = state_q == IDLE && !halted_q;
  assign accept = in_valid && in_ready;
  assign last = cnt_q == CW'(DATA_W - 1);
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  always_comb begin
    op_a = regs_q[rs1];
    op_b = am ? imm : regs_q[rs2];
    rd_val = regs_q[rd];
    sum = {1'b0, op_a} + {1'b0, op_b};
    dif = {1'b0, op_a} - {1'b0, op_b};
    // extra guard bit catches the last bit shifted out; amount 0 leaves it 0
    shl = {1'b0, op_a} << s_r_amount;
    shr = {op_a, 1'b0} >> s_r_amount;
    alu_val = '0;
    alu_c = 1'b0;
    alu_ac = 1'b0;
    legal = 1'b1;
    wb = 1'b1;
    upd = 1'b1;
    case (opcode)
      OP_ADD: begin
        alu_val = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
        alu_ac = (5'(op_a[3:0]) + 5'(op_b[3:0])) > 5'd15;
      end
      OP_SUB, OP_CMP: begin
        alu_val = dif[DATA_W-1:0];
        alu_c = dif[DATA_W];
        alu_ac = op_a[3:0] < op_b[3:0];
        wb = opcode == OP_SUB;
      end
      OP_AND: alu_val = op_a & op_b;
      OP_OR:  alu_val = op_a | op_b;
      OP_XOR: alu_val = op_a ^ op_b;
      OP_NOT: alu_val = ~op_a;
      OP_MOV: alu_val = op_b;
      OP_SHL: begin
        alu_val = shl[DATA_W-1:0];
        alu_c = shl[DATA_W];
      end
      OP_SHR: begin
        alu_val = shr[DATA_W:1];
        alu_c = shr[0];
      end
      OP_ROL: alu_val = (op_a << s_r_amount) | (op_a >> (DATA_W - int'(s_r_amount)));
      OP_INC: begin
        alu_val = rd_val + DATA_W'(1);
        alu_c = &rd_val;
        alu_ac = &rd_val[3:0];
      end
      OP_NOP, OP_MUL, OP_HLT: begin
        wb = 1'b0;
        upd = 1'b0;
      end
      default: begin
        legal = 1'b0;
        wb = 1'b0;
        upd = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      result_q <= '0;
      {zero_q, carry_q, ac_q, parity_q} <= '0;
      {out_valid_q, illegal_q, halted_q} <= '0;
      {acc_q, mcand_q, mplier_q, mul_rd_q, cnt_q} <= '0;
    end else begin
      out_valid_q <= 1'b0;
      illegal_q <= 1'b0;
      if (accept) begin
        out_valid_q <= opcode != OP_MUL;
        illegal_q <= !legal;
        if (opcode == OP_HLT) halted_q <= 1'b1;
        if (opcode == OP_MUL) begin
          // operands latched here so later register writes cannot disturb the product
          mcand_q <= {{DATA_W{1'b0}}, op_a};
          mplier_q <= op_b;
          acc_q <= '0;
          cnt_q <= '0;
          mul_rd_q <= rd;
        end
        if (wb) regs_q[rd] <= alu_val;
        if (upd) begin
          result_q <= {{DATA_W{1'b0}}, alu_val};
          zero_q <= alu_val == '0;
          carry_q <= alu_c;
          ac_q <= alu_ac;
          parity_q <= ~^alu_val;
        end
      end else if (state_q == MULS) begin
        acc_q <= acc_d;
        mcand_q <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          regs_q[mul_rd_q] <= acc_d[DATA_W-1:0];
          result_q <= acc_d;
          zero_q <= acc_d == '0;
          carry_q <= |acc_d[2*DATA_W-1:DATA_W];
          ac_q <= 1'b0;
          parity_q <= ~^acc_d[DATA_W-1:0];
          out_valid_q <= 1'b1;
        end
      end
    end
  end
  assign result = result_q;
  assign out_valid = out_valid_q;
  assign zero_flag = zero_q;
  assign carry_flag = carry_q;
  assign ac_flag = ac_q;
  assign parity_flag = parity_q;
  assign illegal_op = illegal_q;
  assign halted = halted_q;
endmodule

// File: tb/tb_execute_stage_param.sv
// tb_execute_stage_param: randomized and directed checks of execute_stage_param against an arithmetic reference model
module tb_execute_stage_param;
  localparam int W = 8;
  logic clk = 0, reset = 1, in_valid = 0, am = 0;
  logic [4:0] opcode = 0;
  logic [2:0] rd = 0, rs1 = 0, rs2 = 0, s_r_amount = 0;
  logic [W-1:0] imm = 0;
  logic in_ready, out_valid, zero_flag, carry_flag, ac_flag, parity_flag, illegal_op, halted;
  logic [2*W-1:0] result;
  int checks = 0, failures = 0;
  int m_reg [8];
  int m_res;
  bit m_z, m_c, m_ac, m_p, m_halt;
  execute_stage_param dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .am(am), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .s_r_amount(s_r_amount),
    .result(result), .out_valid(out_valid), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .ac_flag(ac_flag), .parity_flag(parity_flag), .illegal_op(illegal_op), .halted(halted)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    foreach (m_reg[i]) m_reg[i] = 0;
    m_res = 0;
    {m_z, m_c, m_ac, m_p, m_halt} = '0;
  endtask
  task automatic check_state(input string tag);
    check({tag, "_z"}, zero_flag, m_z);
    check({tag, "_c"}, carry_flag, m_c);
    check({tag, "_ac"}, ac_flag, m_ac);
    check({tag, "_p"}, parity_flag, m_p);
    check({tag, "_halt"}, halted, m_halt);
    check({tag, "_rdy"}, in_ready, !m_halt);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    in_valid = 0;
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask
  task automatic issue(input int op, input bit a_m, input int d, input int s1, input int s2,
                       input int im, input int n);
    int a, b, rv, val, prod;
    bit c, ac, wb, upd, legal;
    @(negedge clk);
    check("ov_idle", out_valid, 0);
    check("rdy_before", in_ready, 1);
    opcode = op[4:0]; am = a_m; rd = d[2:0]; rs1 = s1[2:0]; rs2 = s2[2:0];
    imm = im[W-1:0]; s_r_amount = n[2:0]; in_valid = 1;
    a = m_reg[s1];
    b = a_m ? im : m_reg[s2];
    rv = m_reg[d];
    val = 0; c = 0; ac = 0; wb = 1; upd = 1; legal = 1;
    case (op)
      1: begin val = a + b; c = val > 255; ac = (a % 16 + b % 16) > 15; end
      2, 13: begin val = a - b; c = a < b; ac = (a % 16) < (b % 16); wb = op == 2; end
      3: val = a & b;
      4: val = a | b;
      5: val = a ^ b;
      6: val = ~a;
      7: val = b;
      9: begin val = a << n; c = n > 0 && ((a >> (8 - n)) & 1) == 1; end
      10: begin val = a >> n; c = n > 0 && ((a >> (n - 1)) & 1) == 1; end
      11: val = (a << n) | (a >> (8 - n));
      12: begin val = rv + 1; c = rv == 255; ac = (rv % 16) == 15; end
      0, 8, 31: begin wb = 0; upd = 0; end
      default: begin legal = 0; wb = 0; upd = 0; end
    endcase
    val &= 255;
    @(negedge clk);
    in_valid = 0;
    if (op == 8) begin
      prod = a * b;
      for (int i = 0; i < W; i++) begin
        check("mul_busy_rdy", in_ready, 0);
        check("mul_busy_ov", out_valid, 0);
        @(negedge clk);
      end
      m_reg[d] = prod & 255;
      m_res = prod;
      m_z = prod == 0;
      m_c = prod > 255;
      m_ac = 0;
      m_p = $countones(prod & 255) % 2 == 0;
    end else begin
      if (wb) m_reg[d] = val;
      if (upd) begin
        m_res = val; m_z = val == 0; m_c = c; m_ac = ac;
        m_p = $countones(val) % 2 == 0;
      end
      if (op == 31) m_halt = 1;
    end
    check("ov_pulse", out_valid, 1);
    check("illegal", illegal_op, !legal);
    if (op != 0 && op != 31) check("result", result, m_res);
    check_state("flags");
  endtask
  task automatic readback(input int r);
    issue(7, 0, r, 0, r, 0, 0);
  endtask
  initial begin
    int ops [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 16, 22};
    model_reset();
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("rst_result", result, 0);
    check("rst_ov", out_valid, 0);
    check("rst_ill", illegal_op, 0);
    check_state("rst");
    issue(7, 1, 1, 0, 0, 'h0F, 0);
    issue(1, 1, 2, 1, 0, 'h01, 0);
    check("tp_add_res", result, 'h10);
    check("tp_add_ac", ac_flag, 1);
    check("tp_add_p", parity_flag, 0);
    readback(2);
    check("tp_reg2", result, 'h10);
    issue(2, 0, 3, 1, 1, 0, 0);
    check("tp_sub_z", zero_flag, 1);
    check("tp_sub_p", parity_flag, 1);
    issue(13, 0, 3, 3, 1, 0, 0);
    check("tp_cmp_c", carry_flag, 1);
    readback(3);
    check("tp_reg3", result, 0);
    issue(7, 1, 5, 0, 0, 'hFF, 0);
    issue(8, 0, 4, 5, 5, 0, 0);
    check("tp_mul_res", result, 'hFE01);
    check("tp_mul_c", carry_flag, 1);
    readback(4);
    check("tp_reg4", result, 1);
    issue(7, 1, 6, 0, 0, 'h81, 0);
    issue(9, 0, 7, 6, 0, 0, 1);
    check("tp_shl", result, 'h02);
    issue(11, 0, 7, 6, 0, 0, 1);
    check("tp_rol", result, 'h03);
    issue(10, 0, 7, 6, 0, 0, 1);
    check("tp_shr", result, 'h40);
    check("tp_shr_c", carry_flag, 1);
    issue(22, 0, 6, 6, 6, 0, 0);
    check("tp_ill_res", result, 'h40);
    readback(6);
    check("tp_reg6", result, 'h81);
    for (int k = 0; k < 300; k++)
      issue(ops[$urandom_range(15)], 1'($urandom), $urandom_range(7), $urandom_range(7),
            $urandom_range(7), $urandom_range(255), $urandom_range(7));
    for (int r = 0; r < 8; r++) readback(r);
    issue(31, 0, 0, 0, 0, 0, 0);
    opcode = 5'b00111; am = 1; rd = 1; imm = 8'h55; in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_rdy", in_ready, 0);
      check("halt_ov", out_valid, 0);
      check("halt_flag", halted, 1);
    end
    do_reset();
    check("post_rst_result", result, 0);
    check_state("post_rst");
    readback(1);
    check("post_rst_reg1", result, 0);
    issue(7, 1, 5, 0, 0, 'hFF, 0);
    @(negedge clk);
    opcode = 5'b01000; am = 0; rd = 4; rs1 = 5; rs2 = 5; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    model_reset();
    for (int i = 0; i < W; i++) begin
      check("abort_ov", out_valid, 0);
      check("abort_result", result, 0);
      check("abort_rdy", in_ready, 1);
      @(negedge clk);
    end
    readback(4);
    check("abort_reg4", result, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
